// File: rtl/trace_sched.sv
// trace_sched: round-robin sharing of one SOML trace engine among NREQ matrix requesters
// Ports: req/req_data come from the requesters, gnt/word_idx go back to them;
// eng_start/eng_sdi drive the trace engine, eng_finish/eng_out return its trace;
// res_valid/res_ready/res_data/res_id/res_err hand the trace on with its requester id.
// Define TRACE_SCHED_MIN_EN to add min_clr and best_valid/best_id/best_trace,
// which track the smallest error-free trace accepted since the last clear.
module trace_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int ENG_LAT = 5,
    parameter int TMO     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        word_idx,
    output logic              eng_start,
    output logic [DW-1:0]     eng_sdi,
    input  logic              eng_finish,
    input  logic [DW-1:0]     eng_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic [2:0]        res_id,
    output logic              res_err
`ifdef TRACE_SCHED_MIN_EN
    ,
    input  logic              min_clr,
    output logic              best_valid,
    output logic [2:0]        best_id,
    output logic [DW-1:0]     best_trace
`endif
);
    localparam int MX = ENG_LAT > TMO ? ENG_LAT : TMO;
    localparam int CW = $clog2(MX + 1);
    typedef enum logic [2:0] {IDLE, START, WAIT, FEED, FIN, RESULT} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    last, gidx, win;
    logic [DW-1:0] words [8];
    // Padding to 8 entries lets the 3-bit grant index select a word directly.
    for (genvar g = 0; g < 8; g++) begin : g_w
        if (g < NREQ) begin : g_on
            assign words[g] = req_data[g*DW +: DW];
        end else begin : g_off
            assign words[g] = '0;
        end
    end
    // Winner is the requester at the smallest circular distance past last.
    always_comb begin
        int best, d;
        win  = '0;
        best = NREQ;
        d    = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(last) - 1) % NREQ;
            if (req[i] && d < best) begin
                best = d;
                win  = 3'(i);
            end
        end
    end
    assign eng_start = state == START;
    assign res_valid = state == RESULT;
    assign eng_sdi   = state == FEED ? words[gidx] : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gidx     <= '0;
            last     <= 3'(NREQ - 1);
            cnt      <= '0;
            word_idx <= '0;
            res_data <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt   <= NREQ'(1) << win;
                    gidx  <= win;
                    state <= START;
                end
                START: begin
                    cnt   <= CW'(ENG_LAT - 1);
                    state <= ENG_LAT == 1 ? FEED : WAIT;
                end
                WAIT: if (cnt == CW'(1)) state <= FEED; else cnt <= cnt - 1'b1;
                FEED: begin
                    word_idx <= word_idx + 2'd1;
                    if (word_idx == 2'd3) begin
                        state <= FIN;
                        cnt   <= CW'(TMO);
                    end
                end
                FIN: if (eng_finish) begin
                    res_data <= eng_out;
                    res_err  <= 1'b0;
                    res_id   <= gidx;
                    state    <= RESULT;
                end else if (cnt == CW'(1)) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                    res_id   <= gidx;
                    state    <= RESULT;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESULT: if (res_ready) begin
                    last  <= gidx;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef TRACE_SCHED_MIN_EN
    // Strict less-than keeps the earlier result on a tie; clear beats update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || min_clr) begin
            best_valid <= 1'b0;
            best_id    <= '0;
            best_trace <= '0;
        end else if (res_valid && res_ready && !res_err && (!best_valid || res_data < best_trace)) begin
            best_valid <= 1'b1;
            best_id    <= res_id;
            best_trace <= res_data;
        end
    end
`endif
endmodule

// File: tb/tb_trace_sched.sv
// tb_trace_sched: randomized self-checking bench for trace_sched with a behavioural engine and arbiter model
module tb_trace_sched;
    localparam int NREQ = 4, DW = 16, ENG_LAT = 5, TMO = 15;
    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req = '0, gnt;
    logic [NREQ*DW-1:0] req_data;
    logic [1:0] word_idx;
    logic eng_start, eng_finish = 1'b0, res_valid, res_ready = 1'b0, res_err;
    logic [DW-1:0] eng_sdi, eng_out = '0, res_data;
    logic [2:0] res_id;
`ifdef TRACE_SCHED_MIN_EN
    logic min_clr = 1'b0, best_valid;
    logic [2:0] best_id;
    logic [DW-1:0] best_trace;
`endif
    logic [DW-1:0] mat [NREQ][4];
    int total = 0, passed = 0, last_m = NREQ - 1;

    trace_sched #(.NREQ(NREQ), .DW(DW), .ENG_LAT(ENG_LAT), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .word_idx(word_idx),
        .eng_start(eng_start), .eng_sdi(eng_sdi), .eng_finish(eng_finish), .eng_out(eng_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_err(res_err)
`ifdef TRACE_SCHED_MIN_EN
        , .min_clr(min_clr), .best_valid(best_valid), .best_id(best_id), .best_trace(best_trace)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mat[i][word_idx];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) if (r[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req = '0; res_ready = 1'b0; eng_finish = 1'b0;
        tick(); tick();
        rst = 1'b0;
        last_m = NREQ - 1;
    endtask

    // Plays the engine for one transaction: checks grant and word timing, answers
    // with w0+w3 after fin_delay FIN cycles (or never if negative), then checks the result.
    task automatic run_txn(input int id, input int fin_delay, input int rdy_delay, input bit spur, output int waited);
        logic [DW-1:0] w [4];
        logic [DW-1:0] exp_data;
        bit exp_err;
        int n;
        waited = 0;
        for (n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) res_ready = 1'b0;
            if (eng_start === 1'b1) break;
        end
        total++;
        if (eng_start !== 1'b1) begin
            $display("FAIL start_wait: eng_start got %b want 1 within 40 cycles", eng_start);
            return;
        end else passed++;
        waited = n;
        total++;
        if (gnt !== (NREQ'(1) << id)) $display("FAIL grant: got %b want %b", gnt, NREQ'(1) << id);
        else passed++;
        for (int c = 1; c < ENG_LAT; c++) begin
            tick();
            total++;
            if (word_idx !== 2'd0 || eng_sdi !== '0 || eng_start !== 1'b0)
                $display("FAIL pre_feed c=%0d: idx=%0d sdi=%h start=%b want 0/0/0", c, word_idx, eng_sdi, eng_start);
            else passed++;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (word_idx !== 2'(k) || eng_sdi !== mat[id][k] || gnt !== (NREQ'(1) << id))
                $display("FAIL feed k=%0d: idx=%0d sdi=%h gnt=%b want %0d/%h/%b", k, word_idx, eng_sdi, gnt, k, mat[id][k], NREQ'(1) << id);
            else passed++;
            w[k] = eng_sdi;
            if (spur && k == 0) req = NREQ'($urandom);
            if (spur && k == 1) begin eng_finish = 1'b1; eng_out = DW'($urandom); end
            if (k == 2) eng_finish = 1'b0;
        end
        exp_err  = fin_delay < 0;
        exp_data = exp_err ? '0 : DW'(mat[id][0] + mat[id][3]);
        if (!exp_err) begin
            for (int c = 0; c <= fin_delay; c++) begin
                tick();
                total++;
                if (res_valid !== 1'b0) $display("FAIL early_valid c=%0d: res_valid got %b want 0", c, res_valid);
                else passed++;
            end
            eng_finish = 1'b1; eng_out = DW'(w[0] + w[3]);
            tick();
            eng_finish = 1'b0; eng_out = DW'($urandom);
        end else begin
            for (n = 1; n <= TMO + 10; n++) begin
                tick();
                if (res_valid === 1'b1) break;
            end
            total++;
            if (n != TMO + 1) $display("FAIL timeout_latency: got %0d want %0d cycles", n, TMO + 1);
            else passed++;
        end
        total++;
        if (res_valid !== 1'b1 || res_data !== exp_data || res_id !== 3'(id) || res_err !== exp_err)
            $display("FAIL result: v=%b data=%h id=%0d err=%b want 1/%h/%0d/%b", res_valid, res_data, res_id, res_err, exp_data, id, exp_err);
        else passed++;
        for (int c = 1; c <= rdy_delay; c++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_data !== exp_data || res_id !== 3'(id) || res_err !== exp_err || eng_start !== 1'b0)
                $display("FAIL hold c=%0d: v=%b data=%h id=%0d err=%b start=%b want 1/%h/%0d/%b/0", c, res_valid, res_data, res_id, res_err, eng_start, exp_data, id, exp_err);
            else passed++;
        end
        res_ready = 1'b1;
        last_m = id;
    endtask

    task automatic test_reset();
        tick();
        total++;
        if (gnt !== '0 || word_idx !== 2'd0 || eng_start !== 1'b0 || eng_sdi !== '0)
            $display("FAIL reset_ctl: gnt=%b idx=%0d start=%b sdi=%h want all 0", gnt, word_idx, eng_start, eng_sdi);
        else passed++;
        total++;
        if (res_valid !== 1'b0 || res_data !== '0 || res_id !== 3'd0 || res_err !== 1'b0)
            $display("FAIL reset_res: v=%b data=%h id=%0d err=%b want all 0", res_valid, res_data, res_id, res_err);
        else passed++;
`ifdef TRACE_SCHED_MIN_EN
        total++;
        if (best_valid !== 1'b0 || best_id !== 3'd0 || best_trace !== '0)
            $display("FAIL reset_best: v=%b id=%0d trace=%h want all 0", best_valid, best_id, best_trace);
        else passed++;
`endif
    endtask

    task automatic test_single();
        int w;
        do_reset();
        mat[2][0] = 16'h0003; mat[2][1] = 16'h1111; mat[2][2] = 16'h2222; mat[2][3] = 16'h0005;
        req = 4'b0100;
        run_txn(2, 2, 0, 1'b0, w);
        req = '0;
        total++;
        if (w != 1) $display("FAIL arb_latency: got %0d want 1", w);
        else passed++;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        req = '1;
        for (int i = 0; i < 8; i++) begin
            run_txn(pick(req), i % 3, 0, 1'b0, w);
            total++;
            if (w != (i == 0 ? 1 : 2)) $display("FAIL rr_spacing i=%0d: got %0d want %0d", i, w, i == 0 ? 1 : 2);
            else passed++;
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int w;
        req = 4'b1000;
        run_txn(pick(req), 1, 10, 1'b0, w);
        req = '0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int w;
        req = 4'b0010;
        run_txn(pick(req), -1, 2, 1'b0, w);
        req = 4'b0001;
        run_txn(pick(req), 0, 1, 1'b0, w);
        req = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int w;
        bit found;
        do_reset();
        mat[1][1] = 16'hbeef;
        req = 4'b0010;
        found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (eng_sdi === 16'hbeef) begin found = 1'b1; break; end
        end
        total++;
        if (!found) $display("FAIL reach_feed: eng_sdi got %h want beef", eng_sdi);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== '0 || eng_start !== 1'b0 || eng_sdi !== '0 || res_valid !== 1'b0 || word_idx !== 2'd0)
            $display("FAIL reset_mid: gnt=%b start=%b sdi=%h v=%b idx=%0d want all 0", gnt, eng_start, eng_sdi, res_valid, word_idx);
        else passed++;
        tick();
        rst = 1'b0;
        last_m = NREQ - 1;
        req = '1;
        run_txn(pick(req), 0, 0, 1'b0, w);
        req = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        int w, fd;
        logic [NREQ-1:0] r;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NREQ; i++) for (int k = 0; k < 4; k++) mat[i][k] = DW'($urandom);
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req = r;
            fd = $urandom_range(0, 7) == 0 ? -1 : int'($urandom_range(0, TMO - 1));
            run_txn(pick(r), fd, $urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
            total++;
            if (w != (it == 0 ? 1 : 2)) $display("FAIL rand_spacing it=%0d: got %0d want %0d", it, w, it == 0 ? 1 : 2);
            else passed++;
        end
        req = '0;
        tick(); tick();
    endtask

`ifdef TRACE_SCHED_MIN_EN
    task automatic test_min();
        int w;
        int ids [3] = '{1, 3, 0};
        logic [DW-1:0] vals [3] = '{16'h0040, 16'h0010, 16'h0010};
        do_reset();
        for (int j = 0; j < 3; j++) begin
            mat[ids[j]][0] = vals[j]; mat[ids[j]][1] = DW'($urandom);
            mat[ids[j]][2] = DW'($urandom); mat[ids[j]][3] = '0;
            req = NREQ'(1) << ids[j];
            run_txn(ids[j], 0, 0, 1'b0, w);
            req = '0;
        end
        tick();
        res_ready = 1'b0;
        total++;
        if (best_valid !== 1'b1 || best_id !== 3'd3 || best_trace !== 16'h0010)
            $display("FAIL best: v=%b id=%0d trace=%h want 1/3/0010", best_valid, best_id, best_trace);
        else passed++;
        min_clr = 1'b1;
        tick();
        min_clr = 1'b0;
        total++;
        if (best_valid !== 1'b0 || best_id !== 3'd0 || best_trace !== '0)
            $display("FAIL min_clr: v=%b id=%0d trace=%h want 0/0/0", best_valid, best_id, best_trace);
        else passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < NREQ; i++) for (int k = 0; k < 4; k++) mat[i][k] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef TRACE_SCHED_MIN_EN
        test_min();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/trace_sched.md
# trace_sched

Round-robin scheduler that shares one SOML trace engine among `NREQ` candidate-matrix requesters. For each granted requester it pulses the engine start and streams the requester's four 2x2 matrix words (w0..w3) into the engine at the engine's fixed sampling latency. It then captures the engine result and returns it with the requester ID over a valid/ready handshake. It sits between the candidate generators and the trace engine in the SOML decoder back end.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `DW`, 16: data and trace width
- `ENG_LAT`, 5: cycles from the `eng_start` cycle to the engine's first `sdi` sample cycle, >=1
- `TMO`, 15: maximum cycles to wait for `eng_finish` after the last fed word
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  level request per requester
- `req_data`  in  NREQ*DW  slice i = requester i's word at index `word_idx`, combinational from `word_idx`
- `gnt`  out  NREQ  one-hot grant, held for the whole transaction
- `word_idx`  out  2  matrix word index being fed
- `eng_start`  out  1  one-cycle start pulse to the engine
- `eng_sdi`  out  DW  word to the engine
- `eng_finish`  in  1  engine result strobe
- `eng_out`  in  DW  engine trace result
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  DW  captured trace
- `res_id`  out  3  granted requester index
- `res_err`  out  1  timeout occurred; `res_data`=0

## Operation
- FSM states: IDLE, START, WAIT, FEED, FIN, RESULT.
- IDLE:
  - If any `req` is set, pick the first set bit scanning circularly from `last+1`.
  - Latch the winner into `gnt` and go to START.
- START:
  - `eng_start`=1 for exactly one cycle.
  - Load a delay counter with ENG_LAT-1.
  - Go to WAIT, or go directly to FEED when ENG_LAT=1.
- WAIT: decrement the counter; enter FEED when it expires.
- FEED:
  - Lasts 4 cycles with `word_idx`=0,1,2,3.
  - `eng_sdi` = `req_data` slice of the granted requester.
  - Then go to FIN and load the timeout counter with TMO.
- FIN:
  - On `eng_finish`, capture `eng_out` into `res_data`, set `res_err`=0, go to RESULT.
  - If the counter reaches 0 without `eng_finish`, set `res_data`=0 and `res_err`=1, go to RESULT.
  - `eng_finish` arriving in any other state is ignored.
- RESULT:
  - Hold `res_valid`=1 and keep all result outputs stable until `res_ready`.
  - On acceptance, set `last` = granted index, clear `gnt`, and return to IDLE.
- Outside FEED, `eng_sdi`=0 and `word_idx`=0.
- Deasserting `req` mid-transaction does not abort the transaction; it completes normally.
- `req` is re-sampled only in IDLE.
- Reset values:
  - All outputs 0 and state IDLE.
  - `last`=NREQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts immediately with no result produced.

## Timing
- If `eng_start` is high in cycle t, `word_idx`=k is presented in cycle t+ENG_LAT+k, for k=0..3.
- Grant decision: `gnt` and `eng_start` are both asserted in the cycle after IDLE sees `req`. This gives 1 cycle of arbitration latency.
- `res_valid` rises in the cycle after `eng_finish` is sampled.
- Acceptance occurs in the cycle where `res_valid` and `res_ready` are both 1. IDLE is entered the next cycle.
- Minimum back-to-back spacing: the next `eng_start` comes 2 cycles after acceptance.
- Throughput is one transaction at a time; there is no overlap of engine runs.

## Configuration
- `TRACE_SCHED_MIN_EN` defined:
  - Adds outputs `best_valid` (1), `best_id` (3) and `best_trace` (DW), plus input `min_clr` (1).
  - On each accepted non-error result, if `best_valid`=0 or `res_data` < `best_trace` (unsigned), update best to the current `res_data` and `res_id`, and set `best_valid`=1.
  - On a tie, the earlier result is kept.
  - `min_clr` clears `best_valid`, `best_id` and `best_trace` to 0.
  - If `min_clr` and an acceptance occur in the same cycle, the clear wins.
- `TRACE_SCHED_MIN_EN` undefined: these ports and the tracker are absent.

## Test plan
- Single request, requester 2, words 0x0003/0x1111/0x2222/0x0005, engine model computes w0+w3: `eng_start` at t, words at t+5..t+8, then `res_valid` with `res_data`=0x0008, `res_id`=2, `res_err`=0.
- All four `req` held high for 8 transactions with `res_ready` tied to 1: grant order is 0,1,2,3,0,1,2,3.
- `res_ready` held low for 10 cycles: `res_valid`, `res_data` and `res_id` stay stable, and no new `eng_start` is issued.
- Engine never asserts `eng_finish`: after TMO=15 cycles in FIN, `res_err`=1 and `res_data`=0; the next transaction proceeds normally.
- `rst` pulsed during FEED: `gnt`, `eng_start`, `eng_sdi` and `res_valid` all go to 0 immediately, and the next grant goes to requester 0.
- With `TRACE_SCHED_MIN_EN` defined, results 0x0040(id1), 0x0010(id3), 0x0010(id0): ends with `best_trace`=0x0010 and `best_id`=3. Then `min_clr` gives `best_valid`=0.
